// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, start-bit validation, framing/overrun
// reporting and a show-ahead byte FIFO.
module uart_rx_fifo #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       serialIn,
  input  logic       rd_en,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned TICK_DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t      state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic [1:0]  vld_q, vld_d;
  logic        armed_q, armed_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [3:0]  scnt_q, scnt_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [7:0]  mem_d [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;

  logic rx, tick, push_req, push, pop;

  assign rx   = sync_q[1];
  assign tick = (tcnt_q == TICK_LAST);

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign dout      = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  assign pop  = rd_en & ~empty;
  assign push = push_req & (~full | pop);

  always_comb begin
    sync_d      = {sync_q[0], serialIn};
    // Synchroniser reset values are not a real line observation; only arm on
    // a high level that has actually propagated from the pin.
    vld_d       = {vld_q[0], 1'b1};
    armed_d     = armed_q | (vld_q[1] & rx);
    state_d     = state_q;
    tcnt_d      = tick ? '0 : tcnt_q + TW'(1);
    scnt_d      = scnt_q;
    bcnt_d      = bcnt_q;
    shreg_d     = shreg_q;
    push_req    = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed_q && !rx) begin
          state_d = START;
          tcnt_d  = '0;
          scnt_d  = '0;
        end
      end
      START: begin
        if (tick) begin
          if (scnt_q == 4'd7) begin
            if (!rx) begin
              state_d = DATA;
              scnt_d  = '0;
              bcnt_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd15) begin
            shreg_d[bcnt_q] = rx;
            bcnt_d          = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd15) begin
            if (rx) begin
              push_req = 1'b1;
              state_d  = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = WAIT_HIGH;
            end
          end
        end
      end
      WAIT_HIGH: begin
        if (rx) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    overrun_d = push_req & full & ~pop;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = shreg_q;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sync_q      <= '1;
      vld_q       <= '0;
      armed_q     <= 1'b0;
      tcnt_q      <= '0;
      scnt_q      <= '0;
      bcnt_q      <= '0;
      shreg_q     <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      vld_q       <= vld_d;
      armed_q     <= armed_d;
      tcnt_q      <= tcnt_d;
      scnt_q      <= scnt_d;
      bcnt_q      <= bcnt_d;
      shreg_q     <= shreg_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front end for `fullControlSystem`: it turns the 9600-baud, 8N1 `serialIn` line into a small queue of validated bytes. The control logic drains that queue to load its programmed values. The block synchronises the pin, detects and validates start bits, and samples each bit at its centre using 16x oversampling. It rejects glitches and framing errors and buffers good bytes in a show-ahead FIFO with overrun reporting.

## Interface
- `CLK_HZ`, 50_000_000, sysclk frequency in Hz
- `BAUD`, 9600, line rate
- `OVERSAMPLE`, 16, ticks per bit period (fixed at 16)
- `FIFO_DEPTH`, 4, byte entries (power of two, ≥2)
- `sysclk` input 1: single clock, all logic rising-edge
- `reset` input 1: asynchronous, active-high; clears all state
- `serialIn` input 1: raw asynchronous RX pin; idle high
- `rd_en` input 1: pop the head byte this cycle; ignored when `empty`
- `dout` output 8: head byte; 8'h00 when `empty`
- `empty` output 1: FIFO holds no bytes
- `full` output 1: FIFO holds FIFO_DEPTH bytes
- `frame_err` output 1: one-cycle pulse when a stop bit is sampled low
- `overrun` output 1: one-cycle pulse when a good byte is dropped because the FIFO is full

## Operation
- Synchroniser: 2-flop chain on `serialIn`; both flops reset to 1. All FSM logic uses the synchronised value `rx`.
- Tick generator: counter 0..TICK_DIV-1 with TICK_DIV = CLK_HZ/(BAUD*16), truncated (325 at the defaults). It emits a one-cycle `tick` at terminal count. It is cleared on start-edge detection so that sampling aligns to the edge.
- Arming: after reset the receiver is unarmed. It arms only once `rx`=1 has been seen. This prevents a reset in the middle of a frame from decoding a data 0 as a start bit.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: armed and `rx`=0 → START; clear tick counter and `scnt` (4-bit sample counter).
  - START: `scnt` increments per tick. At the tick where `scnt`==7:
    - `rx`=0 → DATA, clear `scnt` and `bcnt`;
    - `rx`=1 → IDLE (glitch rejected, nothing reported).
  - DATA: at each tick where `scnt`==15, shift `rx` into bit position `bcnt` (LSB first) and increment `bcnt`. After bit 7 → STOP.
  - STOP: at the tick where `scnt`==15, sample `rx`:
    - `rx`=1: push the byte if not `full` (a pop in the same cycle frees space); otherwise pulse `overrun` and drop the byte. Go to IDLE.
    - `rx`=0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx`=1, then go to IDLE. A break condition yields exactly one `frame_err`.
- FIFO: read/write pointers with one extra wrap bit.
  - `empty` when the pointers are equal; `full` when the indices are equal and the wrap bits differ.
  - Show-ahead read: `dout` = mem[rd_ptr] when not empty.
  - Push and pop in the same cycle: both occur and the count is unchanged, including when full (no overrun).
  - Pop while `empty`: ignored; pointers do not move.
- Reset values: `dout`=8'h00, `empty`=1, `full`=0, `frame_err`=0, `overrun`=0, FSM=IDLE unarmed, pointers=0, `rx`=1.

## Timing
- Bit period = 16×TICK_DIV = 5200 sysclk cycles at the defaults. The nominal period is 5208.3 cycles; the resulting −0.16% error is within 8N1 tolerance.
- Start is validated about 8 ticks after the synchronised falling edge. Data bit n is sampled at 8+16(n+1) ticks; the stop bit at 8+16×9 ticks.
- Latency from the pin falling edge to `empty` deasserting: 2 synchroniser cycles + 152 ticks + 1 cycle (FIFO write registered) = 49403 cycles at the defaults.
- `frame_err` and `overrun` are asserted in the cycle after the stop-sample tick, for exactly 1 cycle.
- Pop timing: `rd_en` seen at edge k means `dout` shows the next entry (or 8'h00 with `empty`=1) after edge k.
- `full`/`empty` update in the cycle following the push or pop.
- Back-to-back frames: a new start can be detected in the first cycle after the return to IDLE. Zero-length idle between a stop bit and the next start is supported.

## Test plan
- Frame 0x55 at 104160 ns/bit (start 0, bits 1,0,1,0,1,0,1,0, stop 1) → `empty` falls once, `dout`=8'h55; `rd_en` 1 cycle → `empty`=1, `dout`=8'h00.
- Three frames 0xAA, 0x08, 0xAA with 200 µs gaps, no reads → FIFO holds 3, `dout`=8'hAA; pops yield AA, 08, AA in order, then `empty`.
- Five good frames with no reads (FIFO_DEPTH=4) → `full`=1 after the 4th; the 5th gives a 1-cycle `overrun` and contents stay the first 4 bytes. Repeat with `rd_en` pulsed on the 5th frame's stop cycle → no `overrun`, 5th byte stored.
- Frame with stop bit 0, line held low 300 µs then high → exactly one `frame_err` pulse, nothing pushed; the next 0x55 frame is received correctly.
- 2 µs low glitch on an idle line → no push, no error. Then `reset` asserted at data bit 3 and released while the line is low → no byte or error until the line returns high; the following 0xAA frame is received cleanly.
